// File: rtl/video_timing_gen.sv
// Pixel-domain raster timing and test-pattern source.
// All outputs are registered and advance together on each pixel clock enable.
module video_timing_gen #(
  parameter int unsigned CEN_DIV   = 2,
  parameter int unsigned HTOTAL    = 384,
  parameter int unsigned HACTIVE   = 256,
  parameter int unsigned HS_START  = 290,
  parameter int unsigned HS_END    = 322,
  parameter int unsigned VTOTAL    = 264,
  parameter int unsigned VACTIVE   = 224,
  parameter int unsigned VS_START  = 236,
  parameter int unsigned VS_END    = 240,
  parameter int unsigned BAR_SHIFT = 5
) (
  input  logic        pxl_clk,
  input  logic        rst_n,
  input  logic [1:0]  pat_sel,
  output logic        pxl_cen,
  output logic [8:0]  hcnt,
  output logic [8:0]  vcnt,
  output logic        pxl_hb,
  output logic        pxl_vb,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [31:0] frame_cnt,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int unsigned DIV_W = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             started_q;
  logic             pxl_cen_q;
  logic [8:0]       hcnt_q, hcnt_d;
  logic [8:0]       vcnt_q, vcnt_d;
  logic             fwrap;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic [1:0]       pat_q, pat_d;
  logic             hb_q, hb_d, vb_q, vb_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             frame_start_q;
  logic [3:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [2:0]       bar;

  // Next-state raster position, frame count, pattern latch and pixel colour.
  // The first enable after reset presents (0,0) without advancing; every later
  // enable advances, so decode below always matches the counters it ships with.
  always_comb begin
    tick        = (div_q == DIV_W'(CEN_DIV - 1));
    div_d       = tick ? '0 : div_q + 1'b1;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    fwrap       = 1'b0;
    if (started_q) begin
      if (hcnt_q == 9'(HTOTAL - 1)) begin
        hcnt_d = '0;
        if (vcnt_q == 9'(VTOTAL - 1)) begin
          vcnt_d = '0;
          fwrap  = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 9'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
    end
    frame_cnt_d = fwrap ? frame_cnt_q + 32'd1 : frame_cnt_q;
    pat_d       = fwrap ? pat_sel : pat_q;

    hb_d = ({1'b0, hcnt_d} >= 10'(HACTIVE));
    vb_d = ({1'b0, vcnt_d} >= 10'(VACTIVE));
    hs_d = ({1'b0, hcnt_d} >= 10'(HS_START)) && ({1'b0, hcnt_d} < 10'(HS_END));
    vs_d = ({1'b0, vcnt_d} >= 10'(VS_START)) && ({1'b0, vcnt_d} < 10'(VS_END));

    bar     = 3'(hcnt_d >> BAR_SHIFT);
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    case (pat_d)
      2'd1: begin
        red_d   = {4{bar[0]}};
        green_d = {4{bar[1]}};
        blue_d  = {4{bar[2]}};
      end
      2'd2: begin
        red_d   = hcnt_d[3:0];
        green_d = vcnt_d[3:0];
        blue_d  = frame_cnt_d[3:0];
      end
      2'd3: begin
        red_d   = (hcnt_d[3] ^ vcnt_d[3]) ? 4'hF : 4'h0;
        green_d = red_d;
        blue_d  = red_d;
      end
      default: ;
    endcase
    if (hb_d || vb_d) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // Divider runs every cycle; all raster state moves only on the divider wrap.
  always_ff @(posedge pxl_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      pxl_cen_q     <= 1'b0;
      started_q     <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_cnt_q   <= '0;
      pat_q         <= '0;
      hb_q          <= 1'b0;
      vb_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      div_q     <= div_d;
      pxl_cen_q <= tick;
      if (tick) begin
        started_q     <= 1'b1;
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        frame_cnt_q   <= frame_cnt_d;
        pat_q         <= pat_d;
        hb_q          <= hb_d;
        vb_q          <= vb_d;
        hs_q          <= hs_d;
        vs_q          <= vs_d;
        frame_start_q <= fwrap;
        red_q         <= red_d;
        green_q       <= green_d;
        blue_q        <= blue_d;
      end
    end
  end

  assign pxl_cen     = pxl_cen_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign pxl_hb      = hb_q;
  assign pxl_vb      = vb_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 10x6 raster with CEN_DIV=3,
// plus a CEN_DIV=1 instance for the always-enabled divider case.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pat_sel;
  logic        pxl_cen, hb, vb, hs, vs, fs;
  logic [8:0]  hcnt, vcnt;
  logic [31:0] frame_cnt;
  logic [3:0]  red, green, blue;

  logic        cen1;
  logic [8:0]  hcnt1, vcnt1;
  logic        hb1, vb1, hs1, vs1, fs1;
  logic [31:0] fc1;
  logic [3:0]  r1, g1, b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CEN_DIV(3), .HTOTAL(10), .HACTIVE(8), .HS_START(8), .HS_END(9),
    .VTOTAL(6), .VACTIVE(4), .VS_START(4), .VS_END(5), .BAR_SHIFT(1)
  ) dut (
    .pxl_clk(clk), .rst_n(rst_n), .pat_sel(pat_sel), .pxl_cen(pxl_cen),
    .hcnt(hcnt), .vcnt(vcnt), .pxl_hb(hb), .pxl_vb(vb), .hs(hs), .vs(vs),
    .frame_start(fs), .frame_cnt(frame_cnt), .red(red), .green(green), .blue(blue)
  );

  video_timing_gen #(
    .CEN_DIV(1), .HTOTAL(10), .HACTIVE(8), .HS_START(8), .HS_END(9),
    .VTOTAL(6), .VACTIVE(4), .VS_START(4), .VS_END(5), .BAR_SHIFT(1)
  ) dut1 (
    .pxl_clk(clk), .rst_n(rst_n), .pat_sel(pat_sel), .pxl_cen(cen1),
    .hcnt(hcnt1), .vcnt(vcnt1), .pxl_hb(hb1), .pxl_vb(vb1), .hs(hs1), .vs(vs1),
    .frame_start(fs1), .frame_cnt(fc1), .red(r1), .green(g1), .blue(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next pixel enable, bounded; returns cycles taken.
  task automatic next_pix(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (pxl_cen !== 1'b1 && n < 8);
    chk("cen_arrives", 32'(pxl_cen), 32'd1);
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input int f, input int p);
    logic [8:0] hh, vv, bb;
    hh = 9'(h);
    vv = 9'(v);
    bb = 9'(h >> 1);
    if (h >= 8 || v >= 4) return 12'h000;
    case (p)
      1:       return {{4{bb[0]}}, {4{bb[1]}}, {4{bb[2]}}};
      2:       return {hh[3:0], vv[3:0], 4'(f)};
      3:       return (hh[3] ^ vv[3]) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_cen"}, 32'(pxl_cen), 0);
    chk({tag, "_pos"}, {14'd0, hcnt, vcnt}, 0);
    chk({tag, "_flags"}, {27'd0, hb, vb, hs, vs, fs}, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
    chk({tag, "_rgb"}, {20'd0, red, green, blue}, 0);
  endtask

  initial begin
    int n, p, active, pulses;
    rst_n   = 1'b0;
    pat_sel = 2'd1;
    #12;
    chk_zero("reset");

    // Divider start-up after release.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("cen3_c1", 32'(pxl_cen), 0);
    chk("cen1_c1", 32'(cen1), 1);
    step();
    chk("cen3_c2", 32'(pxl_cen), 0);
    chk("cen1_c2", 32'(cen1), 1);
    step();
    chk("cen3_c3", 32'(pxl_cen), 1);

    // Four frames: black, bars, checkerboard, gradient.
    pulses = 0;
    for (int f = 0; f < 4; f++) begin
      p = (f == 0) ? 0 : (f == 1) ? 1 : (f == 2) ? 3 : 2;
      active = 0;
      for (int v = 0; v < 6; v++) begin
        for (int h = 0; h < 10; h++) begin
          if (!(f == 0 && v == 0 && h == 0)) begin
            next_pix(n);
            chk("cen_period", 32'(n), 2);
          end
          chk("hcnt", 32'(hcnt), 32'(h));
          chk("vcnt", 32'(vcnt), 32'(v));
          chk("hb", 32'(hb), 32'(h >= 8));
          chk("vb", 32'(vb), 32'(v >= 4));
          chk("hs", 32'(hs), 32'(h == 8));
          chk("vs", 32'(vs), 32'(v == 4));
          chk("fstart", 32'(fs), 32'(h == 0 && v == 0 && f > 0));
          chk("fcnt", frame_cnt, 32'(f));
          chk("rgb", {20'd0, red, green, blue}, {20'd0, exp_rgb(h, v, f, p)});
          if (!hb && !vb) active++;
          if (fs) pulses++;
          if (v == 2 && h == 0 && f == 1) pat_sel = 2'd3;
          if (v == 2 && h == 0 && f == 2) pat_sel = 2'd2;
          step();
          chk("hold_cen", 32'(pxl_cen), 0);
          chk("hold_pos", {14'd0, hcnt, vcnt}, {14'd0, 9'(h), 9'(v)});
          chk("hold_fs", 32'(fs), 32'(h == 0 && v == 0 && f > 0));
        end
      end
      chk("active_px", 32'(active), 32);
    end
    chk("fs_pulses", 32'(pulses), 3);

    // Frame counter wrap at 2^32.
    next_pix(n);
    chk("f4_fcnt", frame_cnt, 4);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt_q;
    chk("forced_fcnt", frame_cnt, 32'hFFFF_FFFF);
    for (int i = 0; i < 60; i++) next_pix(n);
    chk("wrap_fcnt", frame_cnt, 0);
    chk("wrap_pos", {14'd0, hcnt, vcnt}, 0);
    chk("wrap_fs", 32'(fs), 1);

    // Mid-line asynchronous reset at (5,2).
    for (int i = 0; i < 25; i++) next_pix(n);
    chk("pre_rst_pos", {14'd0, hcnt, vcnt}, {14'd0, 9'd5, 9'd2});
    chk("pre_rst_rgb", {20'd0, red, green, blue}, {20'd0, 12'h520});
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("rerun_c2", 32'(pxl_cen), 0);
    step();
    chk("rerun_c3", 32'(pxl_cen), 1);
    chk("rerun_pos", {14'd0, hcnt, vcnt}, 0);
    chk("rerun_fcnt", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
